bs_rotate_queue: RTL and testbench

BS_ROTATE_QUEUE -- requirements
Module: bs_rotate_queue

---
 rtl/bs_rotate_queue_pkg.sv | 15 +
 rtl/bs_rotate_core.sv | 25 ++
 rtl/bs_rotate_queue.sv | 88 ++++++++
 tb/tb_bs_rotate_queue.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bs_rotate_queue_pkg.sv
// Shared constants and the request record for the rotate queue.
// Widths here are the single source for the queue and its rotate core.
package bs_rotate_queue_pkg;

   localparam int unsigned DEPTH_DEF = 4;
   localparam int unsigned DATA_W    = 4;
   localparam int unsigned AMT_W     = 2;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [AMT_W-1:0]  k;
      logic              left;
   } req_t;

endpackage

// File: rtl/bs_rotate_core.sv
// Stateless 4-bit rotator: left or right by 0..3 positions.
// Both directions shift a doubled operand so k=0 passes A through.
module bs_rotate_core
   import bs_rotate_queue_pkg::*;
(
   input  logic [DATA_W-1:0] i_A,
   input  logic [AMT_W-1:0]  i_k,
   input  logic              i_left,
   output logic [DATA_W-1:0] o_Y
);

   logic [2*DATA_W-1:0] dbl;
   logic [2*DATA_W-1:0] shl;
   logic [2*DATA_W-1:0] shr;
   logic [AMT_W:0]      amt_l;

   always_comb begin
      dbl   = {i_A, i_A};
      amt_l = (AMT_W+1)'(DATA_W) - {1'b0, i_k};
      shl   = dbl >> amt_l;
      shr   = dbl >> i_k;
      o_Y   = i_left ? shl[DATA_W-1:0] : shr[DATA_W-1:0];
   end

endmodule

// File: rtl/bs_rotate_queue.sv
// Request FIFO feeding a registered rotate result with valid/ready
// on both sides; capacity is P_DEPTH entries plus the output register.
module bs_rotate_queue
   import bs_rotate_queue_pkg::*;
#(
   parameter int unsigned P_DEPTH = DEPTH_DEF
)
(
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_valid,
   output logic                       o_ready,
   input  logic [DATA_W-1:0]          i_A,
   input  logic [AMT_W-1:0]           i_k,
   input  logic                       i_left,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [DATA_W-1:0]          o_Y,
   output logic [$clog2(P_DEPTH):0]   o_count
);

   localparam int unsigned AW = $clog2(P_DEPTH);
   localparam int unsigned CW = AW + 1;

   req_t              mem_q [P_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] y_q, y_d;
   logic [DATA_W-1:0] head_y;
   logic              push;
   logic              pop;
   req_t              head;

   assign head    = mem_q[rd_ptr_q];
   assign o_ready = (count_q < CW'(P_DEPTH));
   assign o_count = count_q;
   assign o_valid = valid_q;
   assign o_Y     = y_q;

   bs_rotate_core u_core (
      .i_A    (head.a),
      .i_k    (head.k),
      .i_left (head.left),
      .o_Y    (head_y)
   );

   always_comb begin
      push     = i_valid && o_ready && !i_rst;
      pop      = (count_q != '0) && (!valid_q || i_ready);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      valid_d  = valid_q;
      y_d      = y_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      // A fresh load wins over the consume of the current result.
      if (pop) begin
         y_d     = head_y;
         valid_d = 1'b1;
      end else if (valid_q && i_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         y_q      <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         y_q      <= y_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) mem_q[wr_ptr_q] <= '{a: i_A, k: i_k, left: i_left};
   end

endmodule

// File: tb/tb_bs_rotate_queue.sv
// Self-checking bench for bs_rotate_queue: vector table, corner
// sequences and a random run, all scored against a rotate model.
module tb_bs_rotate_queue;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_valid;
   logic       o_ready;
   logic [3:0] i_A;
   logic [1:0] i_k;
   logic       i_left;
   logic       o_valid;
   logic       i_ready;
   logic [3:0] o_Y;
   logic [2:0] o_count;

   int n_cmp = 0;
   int n_bad = 0;
   int n_in  = 0;
   int n_out = 0;
   logic [3:0] sb[$];

   typedef struct {
      logic [3:0] a;
      logic [1:0] k;
      logic       left;
      logic [3:0] y;
   } vec_t;

   vec_t vecs [8];

   bs_rotate_queue #(.P_DEPTH(4)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_A     (i_A),
      .i_k     (i_k),
      .i_left  (i_left),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_Y     (o_Y),
      .o_count (o_count)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] ref_rot(logic [3:0] a, logic [1:0] k,
                                          logic left);
      logic [3:0] y;
      for (int i = 0; i < 4; i++) begin
         if (left) y[i] = a[(i - int'(k) + 4) % 4];
         else      y[i] = a[(i + int'(k)) % 4];
      end
      return y;
   endfunction

   task automatic chk(string nm, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  nm, act, act, exp, exp);
      end
   endtask

   // Scoreboard: values here are the ones the next posedge samples.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         if (o_valid && i_ready) begin
            n_out++;
            if (sb.size() == 0) chk("sb_unexpected", 1, 0);
            else chk("sb_order", int'(o_Y), int'(sb.pop_front()));
         end
         if (i_valid && o_ready) begin
            sb.push_back(ref_rot(i_A, i_k, i_left));
            n_in++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      i_valid = 1'b0;
      rst     = 1'b1;
      tick();
      rst     = 1'b0;
   endtask

   task automatic set_req(logic [3:0] a, logic [1:0] k, logic left);
      i_A    = a;
      i_k    = k;
      i_left = left;
   endtask

   initial begin
      logic [3:0] first_y;
      logic       acc;
      int         nacc;
      int         sent;
      int         cyc;

      vecs[0] = '{4'b1001, 2'd1, 1'b1, 4'b0011};
      vecs[1] = '{4'b1001, 2'd1, 1'b0, 4'b1100};
      vecs[2] = '{4'b0110, 2'd0, 1'b1, 4'b0110};
      vecs[3] = '{4'b0110, 2'd0, 1'b0, 4'b0110};
      vecs[4] = '{4'b1000, 2'd3, 1'b1, 4'b0100};
      vecs[5] = '{4'b1011, 2'd2, 1'b1, 4'b1110};
      vecs[6] = '{4'b0001, 2'd3, 1'b0, 4'b0010};
      vecs[7] = '{4'b1100, 2'd1, 1'b1, 4'b1001};

      rst = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b0;
      set_req(4'd0, 2'd0, 1'b0);
      repeat (2) tick();
      rst = 1'b0;
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_count", int'(o_count), 0);
      chk("rst_y", int'(o_Y), 0);
      chk("rst_ready", int'(o_ready), 1);

      // Single request into an empty block: valid after two edges.
      i_ready = 1'b1;
      foreach (vecs[i]) begin
         set_req(vecs[i].a, vecs[i].k, vecs[i].left);
         i_valid = 1'b1;
         tick();
         i_valid = 1'b0;
         chk("vec_lat_valid0", int'(o_valid), 0);
         tick();
         chk("vec_valid", int'(o_valid), 1);
         chk("vec_y", int'(o_Y), int'(vecs[i].y));
         tick();
      end

      // Fill with the consumer stalled: P_DEPTH+1 accepted.
      do_reset();
      i_ready = 1'b0;
      nacc = 0;
      first_y = ref_rot(4'd3, 2'd1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         set_req(4'(i + 3), 2'(i + 1), 1'b1);
         i_valid = 1'b1;
         if (o_ready) nacc++;
         tick();
      end
      i_valid = 1'b0;
      chk("full_accepted", nacc, 5);
      chk("full_ready", int'(o_ready), 0);
      chk("full_count", int'(o_count), 4);
      chk("full_y_held", int'(o_Y), int'(first_y));
      chk("full_valid", int'(o_valid), 1);

      // Release from full with steady input: one result per cycle.
      i_ready = 1'b1;
      i_valid = 1'b1;
      set_req(4'b0101, 2'd2, 1'b0);
      for (int i = 0; i < 10; i++) begin
         acc = i_valid && o_ready;
         tick();
         chk("thru_valid", int'(o_valid), 1);
         if (acc) set_req(4'($urandom), 2'($urandom), 1'($urandom));
      end
      chk("thru_count", int'(o_count), 3);
      chk("thru_ready", int'(o_ready), 1);

      // Stall again: the FIFO refills and sits at 4.
      i_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         acc = i_valid && o_ready;
         tick();
         if (acc) set_req(4'($urandom), 2'($urandom), 1'($urandom));
      end
      chk("refill_count", int'(o_count), 4);
      tick();
      chk("refill_count_hold", int'(o_count), 4);
      chk("refill_ready", int'(o_ready), 0);
      i_valid = 1'b0;
      i_ready = 1'b1;
      cyc = 0;
      while ((o_valid || o_count != 0) && cyc < 40) begin
         tick();
         cyc++;
      end
      chk("drain_done", int'(o_valid || o_count != 0), 0);
      chk("drain_sb_empty", sb.size(), 0);

      // Reset with three queued entries and a pending result.
      do_reset();
      i_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_req(4'(i + 9), 2'(i), 1'b0);
         i_valid = 1'b1;
         tick();
      end
      chk("pre_rst_valid", int'(o_valid), 1);
      chk("pre_rst_count", int'(o_count), 3);
      rst = 1'b1;
      set_req(4'b1111, 2'd1, 1'b1);
      tick();
      rst = 1'b0;
      i_valid = 1'b0;
      chk("mid_rst_valid", int'(o_valid), 0);
      chk("mid_rst_count", int'(o_count), 0);
      chk("mid_rst_y", int'(o_Y), 0);
      chk("mid_rst_ready", int'(o_ready), 1);
      tick();
      chk("post_rst_valid", int'(o_valid), 0);

      // Random traffic with held requests and random back-pressure.
      do_reset();
      n_in = 0;
      n_out = 0;
      sent = 0;
      cyc = 0;
      i_valid = 1'b0;
      while (sent < 100 && cyc < 4000) begin
         i_ready = 1'($urandom_range(0, 1));
         acc = i_valid && o_ready;
         tick();
         cyc++;
         if (acc) sent++;
         if (acc || !i_valid) begin
            i_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
            set_req(4'($urandom), 2'($urandom), 1'($urandom));
         end
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      cyc = 0;
      while ((o_valid || o_count != 0) && cyc < 40) begin
         tick();
         cyc++;
      end
      chk("rand_sent", sent, 100);
      chk("rand_in", n_in, 100);
      chk("rand_out", n_out, 100);
      chk("rand_sb_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
